mode_counter: RTL

Parametrised, registered step counter that extends the plain enable/increment counter with up/down direction, a run-time modulo limit, wrap/saturate/one-shot modes, synchronous clear and load, and a terminal-count pulse. It serves as the general-purpose counter for timers, address generators and event counters across the lab designs. All outputs are registered, and one step occurs per enabled clock.

---
 rtl/mode_counter.sv | 108 ++++++++++
 1 files changed

// File: rtl/mode_counter.sv
// General-purpose step counter with up/down direction, run-time modulo limit,
// wrap/saturate/one-shot modes, synchronous clear/load and a terminal-count pulse.
module mode_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic [WIDTH-1:0] incr,
   input  logic [WIDTH-1:0] limit,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             done
);

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   logic [WIDTH:0]   cnt_x;
   logic [WIDTH:0]   incr_x;
   logic [WIDTH:0]   lim_x;
   logic [WIDTH:0]   lim_p1;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   up_wrap;
   logic [WIDTH:0]   down_base;
   logic [WIDTH:0]   down_diff;
   logic [WIDTH-1:0] boundary;
   logic [WIDTH-1:0] step_next;
   logic [WIDTH-1:0] load_next;
   logic             step_tc;
   logic             wrap_mode;
   logic             oneshot_mode;
   logic             step_ok;

   // All arithmetic is one bit wider than the counter so nothing overflows.
   assign cnt_x        = {1'b0, count};
   assign incr_x       = {1'b0, incr};
   assign lim_x        = {1'b0, limit};
   assign lim_p1       = lim_x + 1'b1;
   assign sum          = cnt_x + incr_x;
   assign up_wrap      = sum - lim_p1;
   assign down_base    = cnt_x + lim_p1;
   assign down_diff    = down_base - incr_x;
   assign boundary     = dir ? limit : '0;
   assign wrap_mode    = (mode != MODE_SAT) && (mode != MODE_ONESHOT);
   assign oneshot_mode = (mode == MODE_ONESHOT);
   assign step_ok      = en && !(oneshot_mode && done);
   assign load_next    = (load_val > limit) ? limit : load_val;

   always_comb begin
      step_next = count;
      step_tc   = 1'b0;
      if (incr != '0) begin
         if (dir) begin
            if (sum <= lim_x) begin
               step_next = sum[WIDTH-1:0];
            end else if (wrap_mode) begin
               step_tc   = 1'b1;
               step_next = (up_wrap > lim_x) ? limit : up_wrap[WIDTH-1:0];
            end else begin
               step_next = limit;
            end
         end else begin
            if (incr_x <= cnt_x) begin
               step_next = count - incr;
            end else if (wrap_mode) begin
               step_tc   = 1'b1;
               step_next = ((incr_x > down_base) || (down_diff > lim_x)) ? '0 : down_diff[WIDTH-1:0];
            end else begin
               step_next = '0;
            end
         end
         // Saturating modes flag only the arrival onto the boundary, never a hold there.
         if (!wrap_mode) begin
            step_tc = (step_next == boundary) && (count != boundary);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else if (clr) begin
         count <= '0;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else if (load) begin
         count <= load_next;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else begin
         if (step_ok) begin
            count <= step_next;
         end
         tc   <= step_ok && step_tc;
         done <= oneshot_mode && (done || (step_ok && step_tc));
      end
   end

endmodule
